// File: rtl/pipelined_adder_pkg.sv
// Shared types and segment-geometry helpers for the parametrised pipelined adder.
package pipelined_adder_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} adder_op_e;

    function automatic int chunk_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int last_chunk_width(input int width, input int stages);
        return width - (stages - 1) * chunk_width(width, stages);
    endfunction

    function automatic int seg_lsb(input int k, input int width, input int stages);
        return k * chunk_width(width, stages);
    endfunction

    function automatic int seg_width(input int k, input int width, input int stages);
        return (k == stages - 1) ? last_chunk_width(width, stages) : chunk_width(width, stages);
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One carry-chain segment: W-bit add with registered sum, carry and valid tag.
module pipelined_adder_stage #(
    parameter int W = 7
) (
    input  logic         clock0,
    input  logic         reset,
    input  logic         en,
    input  logic         vin,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         vout,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

    // Data only loads behind a valid tag so the outputs hold between results.
    always_ff @(posedge clock0) begin
        if (reset) begin
            vout <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            vout <= vin;
            if (vin) {cout, sum} <= total;
        end
    end

endmodule

// File: rtl/pipelined_adder_param.sv
// WIDTH-bit add/subtract split into STAGES registered carry-chain segments,
// with operand skew and sum deskew so every result bit leaves in one cycle.
module pipelined_adder_param
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 26,
    parameter int STAGES = 4
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             hold,
    input  logic             in_valid,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int LAST = last_chunk_width(WIDTH, STAGES);

    if (WIDTH < 2 || WIDTH > 64 || STAGES < 1 || STAGES > WIDTH || LAST <= 0) begin : g_bad_param
        $error("pipelined_adder_param: illegal WIDTH/STAGES combination");
    end

    logic          en;
    adder_op_e     op;
    logic [STAGES:0] vld_pipe;

    assign en          = ~hold;
    assign op          = adder_op_e'(in_sub);
    assign vld_pipe[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int LSB = seg_lsb(k, WIDTH, STAGES);
        localparam int W   = seg_width(k, WIDTH, STAGES);
        localparam int REM = WIDTH - LSB;

        // a_in/b_in: operand bits [WIDTH-1:LSB] as seen by this segment
        logic [REM-1:0]     a_in, b_in;
        logic               cin, cout;
        logic [W-1:0]       sum;
        logic [LSB+W-1:0]   acc;

        if (k == 0) begin : g_lo
            assign a_in = op_a;
            assign b_in = (op == OP_SUB) ? ~op_b : op_b;
            assign cin  = (op == OP_SUB);
            assign acc  = sum;
        end else begin : g_hi
            localparam int PW   = seg_width(k - 1, WIDTH, STAGES);
            localparam int PREM = WIDTH - seg_lsb(k - 1, WIDTH, STAGES);

            logic [LSB-1:0] low_q;

            // Skew regs sit at the previous segment's level; deskew at this one.
            always_ff @(posedge clock0) begin
                if (reset) begin
                    a_in  <= '0;
                    b_in  <= '0;
                    low_q <= '0;
                end else if (en) begin
                    if (vld_pipe[k-1]) begin
                        a_in <= g_seg[k-1].a_in[PREM-1:PW];
                        b_in <= g_seg[k-1].b_in[PREM-1:PW];
                    end
                    if (vld_pipe[k]) low_q <= g_seg[k-1].acc;
                end
            end

            assign cin = g_seg[k-1].cout;
            assign acc = {sum, low_q};
        end

        pipelined_adder_stage #(.W(W)) u_stage (
            .clock0 (clock0),
            .reset  (reset),
            .en     (en),
            .vin    (vld_pipe[k]),
            .cin    (cin),
            .a      (a_in[W-1:0]),
            .b      (b_in[W-1:0]),
            .vout   (vld_pipe[k+1]),
            .sum    (sum),
            .cout   (cout)
        );
    end

    // Operand sign bits travel alongside the top segment for the overflow test.
    logic a_msb, b_msb;

    always_ff @(posedge clock0) begin
        if (reset) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (en && vld_pipe[STAGES-1]) begin
            a_msb <= g_seg[STAGES-1].a_in[LAST-1];
            b_msb <= g_seg[STAGES-1].b_in[LAST-1];
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out       = g_seg[STAGES-1].acc;
    assign carry_out = g_seg[STAGES-1].cout;
    assign overflow  = (a_msb == b_msb) && (out[WIDTH-1] != a_msb);

endmodule

// File: tb/tb_pipelined_adder_param.sv
// Directed and scoreboarded checks of pipelined_adder_param at 26/4, 8/1 and 8/8.
module tb_pipelined_adder_param;

    logic        clock0 = 1'b0;
    logic        reset  = 1'b1;
    logic        hold   = 1'b0;
    logic        in_valid = 1'b0, in_sub = 1'b0;
    logic [25:0] a = '0, b = '0;
    logic        out_valid, carry_out, overflow;
    logic [25:0] out;

    logic        v8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        s1_v, s1_c, s1_ov, s8_v, s8_c, s8_ov;
    logic [7:0]  s1_out, s8_out;

    int tests = 0;
    int fails = 0;

    always #5 clock0 = ~clock0;

    pipelined_adder_param #(.WIDTH(26), .STAGES(4)) dut (
        .clock0(clock0), .reset(reset), .hold(hold), .in_valid(in_valid), .in_sub(in_sub),
        .op_a(a), .op_b(b), .out_valid(out_valid), .out(out), .carry_out(carry_out),
        .overflow(overflow));

    pipelined_adder_param #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clock0(clock0), .reset(reset), .hold(hold), .in_valid(v8), .in_sub(sub8),
        .op_a(a8), .op_b(b8), .out_valid(s1_v), .out(s1_out), .carry_out(s1_c),
        .overflow(s1_ov));

    pipelined_adder_param #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clock0(clock0), .reset(reset), .hold(hold), .in_valid(v8), .in_sub(sub8),
        .op_a(a8), .op_b(b8), .out_valid(s8_v), .out(s8_out), .carry_out(s8_c),
        .overflow(s8_ov));

    typedef struct {
        logic        sub;
        logic [25:0] a;
        logic [25:0] b;
        logic [25:0] eo;
        logic        ec;
        logic        eov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference built from integer arithmetic: {carry, overflow, result}.
    function automatic logic [27:0] model26(input logic s, input logic [25:0] x, input logic [25:0] y);
        longint ux, uy, sx, sy, rs;
        logic   c, ov;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rs = s ? sx - sy : sx + sy;
        ov = (rs > 64'sd33554431) || (rs < -64'sd33554432);
        c  = s ? (ux >= uy) : (ux + uy > 64'd67108863);
        return {c, ov, 26'(rs)};
    endfunction

    task automatic send26(input vec_t v, input string nm);
        int lat;
        logic [25:0] held;
        @(negedge clock0);
        in_sub = v.sub; a = v.a; b = v.b; in_valid = 1'b1;
        @(negedge clock0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clock0);
            lat++;
        end
        chk($sformatf("%s_latency", nm), 64'(lat), 64'd4);
        chk($sformatf("%s_result", nm), {carry_out, overflow, out}, {v.ec, v.eov, v.eo});
        held = out;
        @(negedge clock0);
        chk($sformatf("%s_pulse", nm), 64'(out_valid), 64'd0);
        chk($sformatf("%s_stable", nm), 64'(out), 64'(held));
    endtask

    task automatic run8(input string nm, input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] eo, input logic ec, input logic eov);
        int l1, l8, p1, p8;
        logic [9:0] r1, r8;
        l1 = 0; l8 = 0; p1 = 0; p8 = 0; r1 = '0; r8 = '0;
        @(negedge clock0);
        sub8 = s; a8 = x; b8 = y; v8 = 1'b1;
        @(negedge clock0);
        v8 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (s1_v) begin p1++; if (l1 == 0) begin l1 = c; r1 = {s1_c, s1_ov, s1_out}; end end
            if (s8_v) begin p8++; if (l8 == 0) begin l8 = c; r8 = {s8_c, s8_ov, s8_out}; end end
            if (c < 12) @(negedge clock0);
        end
        chk($sformatf("%s_s1_latency", nm), 64'(l1), 64'd1);
        chk($sformatf("%s_s1_result", nm), 64'(r1), 64'({ec, eov, eo}));
        chk($sformatf("%s_s1_pulses", nm), 64'(p1), 64'd1);
        chk($sformatf("%s_s8_latency", nm), 64'(l8), 64'd8);
        chk($sformatf("%s_s8_result", nm), 64'(r8), 64'({ec, eov, eo}));
        chk($sformatf("%s_s8_pulses", nm), 64'(p8), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [27:0] q[$];
        logic [27:0] exp_r;
        int sent, got, cyc;
        logic prev_en, fresh;

        tbl[0] = '{1'b0, 26'h3FFFFFF,   26'd1,        26'd0,        1'b1, 1'b0};
        tbl[1] = '{1'b1, 26'd5,         26'd7,        26'd67108862, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 26'd33554431,  26'd1,        26'd33554432, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 26'd7,         26'd5,        26'd2,        1'b1, 1'b0};
        tbl[4] = '{1'b0, 26'd0,         26'd0,        26'd0,        1'b0, 1'b0};
        tbl[5] = '{1'b1, 26'd0,         26'd0,        26'd0,        1'b1, 1'b0};
        tbl[6] = '{1'b1, 26'd33554432,  26'd1,        26'd33554431, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 26'd12345678,  26'd23456789, 26'd35802467, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 26'h2AAAAAA,   26'h1555555,  26'h3FFFFFF,  1'b0, 1'b0};
        tbl[9] = '{1'b1, 26'h1000000,   26'h1000001,  26'h3FFFFFF,  1'b0, 1'b0};

        // Reset held with live inputs: everything must stay at zero.
        in_valid = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 26'($urandom()); b = 26'($urandom()); in_sub = 1'($urandom());
            a8 = 8'($urandom()); b8 = 8'($urandom());
            @(negedge clock0);
            chk("reset_26", {out_valid, carry_out, overflow, out}, 64'd0);
            chk("reset_s1", {s1_v, s1_c, s1_ov, s1_out}, 64'd0);
            chk("reset_s8", {s8_v, s8_c, s8_ov, s8_out}, 64'd0);
        end
        in_valid = 1'b0; v8 = 1'b0;
        @(negedge clock0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) send26(tbl[i], $sformatf("vec%0d", i));

        // Random stream with holds, including a 3-cycle hold and a toggling window.
        sent = 0; got = 0; cyc = 0; prev_en = 1'b0; fresh = 1'b1;
        while ((sent < 800 || q.size() > 0) && cyc < 6000) begin
            @(negedge clock0);
            if (prev_en && out_valid) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_result", 64'd1, 64'd0);
                end else begin
                    exp_r = q.pop_front();
                    chk($sformatf("rnd_result_%0d", got), {carry_out, overflow, out}, exp_r);
                    got++;
                end
            end
            if (cyc >= 300 && cyc <= 302)     hold = 1'b1;
            else if (cyc >= 500 && cyc < 540) hold = (cyc % 2 == 1);
            else                              hold = ($urandom_range(0, 4) == 0);
            if (sent < 800) begin
                in_valid = 1'b1;
                if (fresh) begin
                    a = 26'($urandom()); b = 26'($urandom()); in_sub = 1'($urandom());
                    fresh = 1'b0;
                end
                if (!hold) begin
                    q.push_back(model26(in_sub, a, b));
                    sent++;
                    fresh = 1'b1;
                end
            end else begin
                in_valid = 1'b0;
            end
            prev_en = !hold;
            cyc++;
        end
        hold = 1'b0; in_valid = 1'b0;
        chk("rnd_result_count", 64'(got), 64'd800);

        // Reset with three results in flight: none may ever emerge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock0);
            in_valid = 1'b1; in_sub = 1'b0; a = 26'(i + 1); b = 26'd100;
        end
        @(negedge clock0);
        in_valid = 1'b0; reset = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock0);
            chk($sformatf("midreset_valid_%0d", j), 64'(out_valid), 64'd0);
            if (j == 1) reset = 1'b0;
        end
        send26(tbl[7], "post_reset");

        run8("add200_100", 1'b0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0);
        run8("add127_1",   1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1);
        run8("sub3_5",     1'b1, 8'd3,   8'd5,   8'd254, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_param.md
Name: pipelined_adder_param

Overview:
Parametrised successor to the fixed 26-bit pipelined adder. Splits a WIDTH-bit add/subtract into STAGES carry-chain segments, with one register stage per segment.
Adds a valid tag, a global hold (stall), add/sub mode, carry-out and signed overflow, all aligned to the result.
Used as the arithmetic datapath benchmark block, and compared post-route against its RTL in the same style as the existing adder benches.

Parameters:
WIDTH, 26, operand/result width in bits; legal range 2..64.
STAGES, 4, pipeline segments, and also the latency in cycles; legal range 1..WIDTH.
CHUNK, derived = ceil(WIDTH/STAGES), segment width; the last segment takes WIDTH-(STAGES-1)*CHUNK bits, which must be >0 (elaboration error otherwise).

Ports:
clock0  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
hold  input  1  stall; while 1 no pipeline register changes and inputs are ignored
in_valid  input  1  op_a/op_b/in_sub are captured on this cycle when hold=0
in_sub  input  1  0: a+b, 1: a-b
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
out_valid  output  1  out/carry_out/overflow hold a new result
out  output  WIDTH  sum/difference modulo 2^WIDTH
carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset (sampled at clock0 edge): all valid bits, skew/deskew registers, carries and outputs go to 0. Reset overrides hold and in_valid.
- Reset mid-operation: in-flight results are discarded. out_valid=0 from the first edge with reset=1, and none of the in-flight results ever emerges.
- Sub mode: B operand = ~op_b, carry-in = 1. Add mode: carry-in = 0. in_sub travels with its data.
- Stage k (0..STAGES-1):
  - adds chunk k of A and B (delayed k cycles by skew registers) plus the registered carry from stage k-1 (stage 0 uses the carry-in);
  - registers its chunk sum and carry-out;
  - lower chunk sums are delayed by deskew registers so that all chunks reach out in the same cycle.
- Latency: result is valid exactly STAGES enabled (hold=0) cycles after capture. Throughput: one result per cycle.
- Valid pipeline: a valid bit per stage, shifting when hold=0. A stage's data registers load only when its incoming valid=1; otherwise they keep their value, so out is stable between results.
- out_valid is registered and equals the last-stage valid bit. It is 1 for exactly one enabled cycle per accepted input. Under hold it is frozen at its current value.
- carry_out = carry out of the top segment.
- overflow = (A[MSB]==B'[MSB]) && (out[MSB]!=A[MSB]), where B' is the post-inversion operand.
- hold=1 with in_valid=1: the input is not captured; the source must re-present it.
- hold toggling every cycle: results are neither duplicated nor dropped.
- STAGES=1: single registered adder, latency 1.
- STAGES=WIDTH: 1-bit segments.
- No combinational path from any input to any output.

Decomposition:
- Package pipelined_adder_pkg:
  - function chunk_width(WIDTH,STAGES);
  - function last_chunk_width(WIDTH,STAGES);
  - localparam-style helpers for segment LSB index;
  - typedef enum logic {OP_ADD, OP_SUB} adder_op_e.
- Sub-module pipelined_adder_stage:
  - one segment: chunk adder, carry register, valid register, hold gating;
  - parametrised by segment width and index.
- Generate loop in the top instantiates STAGES of them, plus the skew/deskew shift registers.

Test Plan:
- Defaults, reset held 10 cycles -> out=0, out_valid=0, carry_out=0, overflow=0 throughout, even with in_valid=1.
- Add 67108863+1, single input -> out_valid=1 exactly 4 cycles later for one cycle; out=0, carry_out=1 (carry ripples through all 4 segments); overflow=0.
- Sub 5-7 -> out=67108862, carry_out=0, overflow=0. Add 33554431+1 -> out=33554432, overflow=1, carry_out=0.
- 800 random back-to-back pairs (random in_sub) vs behavioural model, with hold asserted randomly (including 3 consecutive cycles mid-stream) -> zero mismatches; result count equals input count and order is preserved.
- Reset asserted for 2 cycles with 3 results in flight -> out_valid=0 from the next edge; no stale result appears after reset deasserts. First new input gives a correct result 4 cycles later.
- WIDTH=8, STAGES=1: 200+100 -> out=44, carry_out=1, latency 1. WIDTH=8, STAGES=8: 127+1 -> out=128, overflow=1, latency 8.
